// File: rtl/tc_add_feeder.sv
// Operand feeder for the tensor-core adder: gathers SHAPE_N lane beats into one
// block, captures the control sideband with the first beat and holds the block until taken.
module tc_add_feeder #(
  parameter int SHAPE_N       = 8,
  parameter int SHAPE_K       = 8,
  parameter int ELEMENT_WIDTH = 9,
  parameter int CTRL_C_WIDTH  = 16,
  parameter int DEPTH_WARP    = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [SHAPE_K*ELEMENT_WIDTH-1:0]         row_i,
  input  logic                                     row_valid_i,
  output logic                                     row_ready_o,
  input  logic [2:0]                               rm_i,
  input  logic [CTRL_C_WIDTH-1:0]                  ctrl_c_i,
  input  logic [2:0]                               ctrl_rm_i,
  input  logic [7:0]                               ctrl_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]                    ctrl_warpid_i,
  input  logic                                     flush_i,
  output logic [SHAPE_N*SHAPE_K*ELEMENT_WIDTH-1:0] r_v_o,
  output logic [2:0]                               rm_o,
  output logic [CTRL_C_WIDTH-1:0]                  ctrl_c_o,
  output logic [2:0]                               ctrl_rm_o,
  output logic [7:0]                               ctrl_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]                    ctrl_warpid_o,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [$clog2(SHAPE_N+1)-1:0]             lane_cnt_o
);

  localparam int LANE_W = SHAPE_K * ELEMENT_WIDTH;
  localparam int BLK_W  = SHAPE_N * LANE_W;
  localparam int CNT_W  = $clog2(SHAPE_N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        lane_cnt_r;
  logic [BLK_W-1:0]        r_v_r;
  logic [2:0]              rm_r;
  logic [CTRL_C_WIDTH-1:0] ctrl_c_r;
  logic [2:0]              ctrl_rm_r;
  logic [7:0]              ctrl_reg_idxw_r;
  logic [DEPTH_WARP-1:0]   ctrl_warpid_r;
  logic                    out_valid_r;
  logic                    row_ready_r;

  logic                    accept_s;
  logic                    last_lane_s;

  // ready is a registered copy of "not in ISSUE", so accept never overlaps issue
  assign accept_s    = row_valid_i && row_ready_r && !flush_i;
  assign last_lane_s = (lane_cnt_r == CNT_W'(SHAPE_N - 1));

  // Feeder FSM: lane fill, sideband capture, hold-until-taken and flush handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      lane_cnt_r      <= '0;
      r_v_r           <= '0;
      rm_r            <= 3'd0;
      ctrl_c_r        <= '0;
      ctrl_rm_r       <= 3'd0;
      ctrl_reg_idxw_r <= 8'd0;
      ctrl_warpid_r   <= '0;
      out_valid_r     <= 1'b0;
      row_ready_r     <= 1'b1;
    end else if (flush_i) begin
      // block data and sideband are left as-is; the next block overwrites them
      state_r     <= IDLE;
      lane_cnt_r  <= '0;
      out_valid_r <= 1'b0;
      row_ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE, FILL: begin
          if (accept_s) begin
            for (int l = 0; l < SHAPE_N; l++) begin
              if (lane_cnt_r == CNT_W'(l)) begin
                r_v_r[l*LANE_W +: LANE_W] <= row_i;
              end
            end
            if (state_r == IDLE) begin
              rm_r            <= rm_i;
              ctrl_c_r        <= ctrl_c_i;
              ctrl_rm_r       <= ctrl_rm_i;
              ctrl_reg_idxw_r <= ctrl_reg_idxw_i;
              ctrl_warpid_r   <= ctrl_warpid_i;
            end
            lane_cnt_r <= lane_cnt_r + CNT_W'(1);
            // a single-lane block goes straight from IDLE to ISSUE here
            if (last_lane_s) begin
              state_r     <= ISSUE;
              out_valid_r <= 1'b1;
              row_ready_r <= 1'b0;
            end else begin
              state_r <= FILL;
            end
          end
        end
        ISSUE: begin
          if (out_ready_i) begin
            state_r     <= IDLE;
            lane_cnt_r  <= '0;
            out_valid_r <= 1'b0;
            row_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          lane_cnt_r  <= '0;
          out_valid_r <= 1'b0;
          row_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign row_ready_o     = row_ready_r;
  assign out_valid_o     = out_valid_r;
  assign lane_cnt_o      = lane_cnt_r;
  assign r_v_o           = r_v_r;
  assign rm_o            = rm_r;
  assign ctrl_c_o        = ctrl_c_r;
  assign ctrl_rm_o       = ctrl_rm_r;
  assign ctrl_reg_idxw_o = ctrl_reg_idxw_r;
  assign ctrl_warpid_o   = ctrl_warpid_r;

endmodule
